// File: rtl/store_buffer_pkg.sv
// store_buffer_pkg: shared definitions for the store buffer.
//   - st_op encodings (SW, SH, SB, SWL, SWR; 5..7 reserved)
//   - SRAM size encodings
//   - buffered entry layout {addr, size, wstrb, wdata} and its width
//   - drain FSM state encodings
package store_buffer_pkg;

  localparam logic [2:0] OP_SW  = 3'd0;
  localparam logic [2:0] OP_SH  = 3'd1;
  localparam logic [2:0] OP_SB  = 3'd2;
  localparam logic [2:0] OP_SWL = 3'd3;
  localparam logic [2:0] OP_SWR = 3'd4;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // addr(32) + size(2) + wstrb(4) + wdata(32)
  localparam int ENTRY_W = 70;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } sb_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } sb_state_t;

endpackage

// File: rtl/store_buffer_fmt.sv
// store_fmt: combinational store formatter.
// Turns a committed store (st_op, st_addr, st_data) into the SRAM-ready
// fields (fmt_addr, fmt_size, fmt_wstrb, fmt_wdata) with lane-aligned data.
// Ports:
//   st_op[2:0]   in   store opcode (see store_buffer_pkg)
//   st_addr[31:0] in  byte address
//   st_data[31:0] in  rt register value
//   fmt_addr, fmt_size, fmt_wstrb, fmt_wdata  out  formatted entry fields
module store_fmt
  import store_buffer_pkg::*;
(
  input  logic [2:0]  st_op,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic [31:0] fmt_addr,
  output logic [1:0]  fmt_size,
  output logic [3:0]  fmt_wstrb,
  output logic [31:0] fmt_wdata
);

  logic [1:0] off;
  assign off = st_addr[1:0];

  always_comb begin
    // Reserved opcodes fall through with these defaults: no lanes enabled,
    // but the request is still issued.
    fmt_addr  = st_addr;
    fmt_size  = SIZE_WORD;
    fmt_wstrb = 4'b0000;
    fmt_wdata = st_data;
    case (st_op)
      OP_SW: begin
        fmt_wstrb = 4'b1111;
      end
      OP_SH: begin
        fmt_size  = SIZE_HALF;
        fmt_wstrb = off[1] ? 4'b1100 : 4'b0011;
        fmt_wdata = {2{st_data[15:0]}};
      end
      OP_SB: begin
        fmt_size  = SIZE_BYTE;
        fmt_wstrb = 4'b0001 << off;
        fmt_wdata = {4{st_data[7:0]}};
      end
      OP_SWL: begin
        // Upper (off+1) bytes of rt land in the low lanes of the word.
        fmt_addr  = {st_addr[31:2], 2'b00};
        fmt_wstrb = 4'b1111 >> (2'd3 - off);
        fmt_wdata = st_data >> {(2'd3 - off), 3'b000};
      end
      OP_SWR: begin
        // Lower (4-off) bytes of rt land in the high lanes of the word.
        fmt_addr  = {st_addr[31:2], 2'b00};
        fmt_wstrb = 4'b1111 << off;
        fmt_wdata = st_data << {off, 3'b000};
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/store_buffer.sv
// store_buffer: FIFO of committed stores drained to the data SRAM one write
// at a time, with a load-stall probe.
// Handshakes:
//   st_valid/st_ready : a store is taken on a cycle with both high; st_ready is
//                       simply !sb_full (no bypass while full, even on a pop).
//   data_sram_req/addr_ok : request is taken on a cycle with both high; all
//                       data_sram_* outputs hold steady while req waits.
//   data_sram_data_ok : completes the single outstanding write; ignored
//                       unless the drain FSM is in WAIT.
// Ports: clk, resetn (async active-low); st_valid, st_ready, st_op, st_addr,
//   st_data; data_sram_req, _wr, _size, _wstrb, _addr, _wdata, _addr_ok,
//   _data_ok; ld_valid, ld_addr, ld_stall; sb_empty, sb_full; dbg_state
//   (drain FSM state).
// Build option: STORE_BUF_ADDR_CHECK_EN -- when defined, a load stalls only on
//   a word-address match with an occupied entry; otherwise on any occupancy.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [2:0]  st_op,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic        data_sram_req,
  output logic        data_sram_wr,
  output logic [1:0]  data_sram_size,
  output logic [3:0]  data_sram_wstrb,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  input  logic        data_sram_addr_ok,
  input  logic        data_sram_data_ok,
  input  logic        ld_valid,
  input  logic [31:0] ld_addr,
  output logic        ld_stall,
  output logic        sb_empty,
  output logic        sb_full,
  output logic [1:0]  dbg_state
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);

  sb_state_t state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] mem_d [DEPTH];

  logic [31:0] fmt_addr;
  logic [1:0]  fmt_size;
  logic [3:0]  fmt_wstrb;
  logic [31:0] fmt_wdata;
  sb_entry_t   fmt_entry;
  sb_entry_t   head_entry;
  logic        enq;
  logic        pop;
  logic        ld_addr_unused;

  store_fmt u_fmt (
    .st_op    (st_op),
    .st_addr  (st_addr),
    .st_data  (st_data),
    .fmt_addr (fmt_addr),
    .fmt_size (fmt_size),
    .fmt_wstrb(fmt_wstrb),
    .fmt_wdata(fmt_wdata)
  );

  assign fmt_entry = '{addr: fmt_addr, size: fmt_size, wstrb: fmt_wstrb, wdata: fmt_wdata};

  assign sb_full   = (count_q == CNT_DEPTH);
  assign st_ready  = !sb_full;
  assign sb_empty  = (count_q == '0) && (state_q == ST_IDLE);
  assign enq       = st_valid && st_ready;
  // Only a data_ok in WAIT retires the head; strays elsewhere are dropped.
  assign pop       = (state_q == ST_WAIT) && data_sram_data_ok;
  assign dbg_state = state_q;

  // Drain FSM next state. IDLE looks at the incoming enqueue as well so a
  // store into an empty buffer is requested on the very next cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if ((count_q != '0) || enq) state_d = ST_REQ;
      ST_REQ:  if (data_sram_addr_ok) state_d = ST_WAIT;
      ST_WAIT: begin
        if (data_sram_data_ok) begin
          state_d = ((count_q > CNT_W'(1)) || enq) ? ST_REQ : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FIFO pointers, count and storage. The head stays occupied through
  // REQ and WAIT and is only released by the pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
    if (enq) begin
      mem_d[wr_ptr_q] = fmt_entry;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({enq, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  // SRAM request: driven from the head entry only while in REQ; the head
  // cannot change until the pop, which gives the hold property for free.
  always_comb begin
    head_entry      = sb_entry_t'(mem_q[rd_ptr_q]);
    data_sram_req   = (state_q == ST_REQ);
    data_sram_wr    = data_sram_req;
    data_sram_size  = '0;
    data_sram_wstrb = '0;
    data_sram_addr  = '0;
    data_sram_wdata = '0;
    if (data_sram_req) begin
      data_sram_size  = head_entry.size;
      data_sram_wstrb = head_entry.wstrb;
      data_sram_addr  = head_entry.addr;
      data_sram_wdata = head_entry.wdata;
    end
  end

`ifdef STORE_BUF_ADDR_CHECK_EN
  // An entry is occupied when its distance from the read pointer (modulo
  // DEPTH) is below the count.
  logic addr_hit;
  always_comb begin
    addr_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(PTR_W'(i) - rd_ptr_q) < count_q) &&
          (mem_q[i][ENTRY_W-1 -: 30] == ld_addr[31:2])) begin
        addr_hit = 1'b1;
      end
    end
  end
  assign ld_stall       = ld_valid && addr_hit;
  assign ld_addr_unused = ^ld_addr[1:0];
`else
  assign ld_stall       = ld_valid && !sb_empty;
  assign ld_addr_unused = ^ld_addr;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed spec vectors plus randomized stores, checked by a
// queue-based reference model and an expected-request scoreboard.
module tb_store_buffer;
  import store_buffer_pkg::*;

  localparam int DEPTH = 4;

  logic        clk;
  logic        resetn;
  logic        st_valid;
  logic        st_ready;
  logic [2:0]  st_op;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        data_sram_req;
  logic        data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        ld_stall;
  logic        sb_empty;
  logic        sb_full;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [69:0] exp_q[$];   // expected SRAM requests, in issue order
  logic [69:0] pend[$];    // model: occupied entries, oldest first
  bit outstanding = 0;     // model: one write accepted, awaiting data_ok
  bit auto_resp = 0;
  bit ld_rand = 0;
  bit resp_pending = 0;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn),
    .st_valid(st_valid), .st_ready(st_ready), .st_op(st_op),
    .st_addr(st_addr), .st_data(st_data),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_stall(ld_stall),
    .sb_empty(sb_empty), .sb_full(sb_full), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    resetn = 0;
    repeat (3) @(posedge clk);
    #1 resetn = 1;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // ---------------- reference model ----------------
  function automatic logic [69:0] model_fmt(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] d);
    int          off = int'(a[1:0]);
    logic [31:0] wa = a;
    logic [1:0]  sz = 2'd2;
    logic [3:0]  ws = 4'h0;
    logic [31:0] wd = d;
    case (op)
      3'd0: ws = 4'hF;
      3'd1: begin sz = 2'd1; ws = (off >= 2) ? 4'hC : 4'h3; wd = d[15:0] * 32'h0001_0001; end
      3'd2: begin sz = 2'd0; ws = 4'(1 << off); wd = d[7:0] * 32'h0101_0101; end
      3'd3: begin wa = a & ~32'h3; ws = 4'((1 << (off + 1)) - 1); wd = d >> (8 * (3 - off)); end
      3'd4: begin wa = a & ~32'h3; ws = 4'(((1 << (4 - off)) - 1) << off); wd = d << (8 * off); end
      default: ws = 4'h0;
    endcase
    return {wa, sz, ws, wd};
  endfunction

  function automatic logic model_stall();
    if (!ld_valid) return 1'b0;
`ifdef STORE_BUF_ADDR_CHECK_EN
    foreach (pend[i]) if (pend[i][69:40] == ld_addr[31:2]) return 1'b1;
    return 1'b0;
`else
    return pend.size() != 0;
`endif
  endfunction

  task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got timeout expected DUT response at %0t", name, $time);
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial forever begin
    @(negedge clk);
    if (!resetn) begin
      chk("rst_req", data_sram_req, 0);
      chk("rst_wr", data_sram_wr, 0);
      chk("rst_size", data_sram_size, 0);
      chk("rst_wstrb", data_sram_wstrb, 0);
      chk("rst_addr", data_sram_addr, 0);
      chk("rst_wdata", data_sram_wdata, 0);
      chk("rst_sb_empty", sb_empty, 1);
      chk("rst_sb_full", sb_full, 0);
      chk("rst_st_ready", st_ready, 1);
      chk("rst_ld_stall", ld_stall, 0);
      chk("rst_state", dbg_state, ST_IDLE);
      pend.delete();
      exp_q.delete();
      outstanding = 0;
    end else begin
      logic exp_req;
      exp_req = (pend.size() != 0) && !outstanding;
      chk("st_ready", st_ready, pend.size() < DEPTH);
      chk("sb_full", sb_full, pend.size() == DEPTH);
      chk("sb_empty", sb_empty, pend.size() == 0);
      chk("req", data_sram_req, exp_req);
      chk("wr", data_sram_wr, data_sram_req);
      chk("ld_stall", ld_stall, model_stall());
      if (data_sram_req) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_req: got addr %0h expected no request", data_sram_addr);
        end else begin
          chk("sram_fields", {data_sram_addr, data_sram_size, data_sram_wstrb, data_sram_wdata},
              exp_q[0]);
          if (data_sram_addr_ok) void'(exp_q.pop_front());
        end
      end
      // advance the model to the next edge
      if (st_valid && (pend.size() < DEPTH)) pend.push_back(model_fmt(st_op, st_addr, st_data));
      if (outstanding && data_sram_data_ok) begin
        void'(pend.pop_front());
        outstanding = 0;
      end else if (exp_req && data_sram_addr_ok) begin
        outstanding = 1;
      end
    end
  end

  // ---------------- SRAM responder / load prober ----------------
  initial forever begin
    @(negedge clk);
    if (!resetn) resp_pending = 0;
    else if (data_sram_req && data_sram_addr_ok) resp_pending = 1;
    else if (resp_pending && data_sram_data_ok) resp_pending = 0;
  end

  initial forever begin
    @(posedge clk);
    #2;
    if (auto_resp) begin
      data_sram_addr_ok = ($urandom_range(0, 2) != 0);
      // data_ok sometimes pulses with nothing outstanding; it must be ignored
      data_sram_data_ok = resp_pending ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
    end
    if (ld_rand) begin
      ld_valid = $urandom_range(0, 1);
      ld_addr  = 32'h6000 + $urandom_range(0, 31);
    end
  end

  // ---------------- driver tasks (called at posedge + 1) ----------------
  task automatic send_store(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    bit done = 0;
    st_valid = 1; st_op = op; st_addr = a; st_data = d;
    while (!done && n < 100) begin
      @(negedge clk);
      if (st_ready) begin
        exp_q.push_back(model_fmt(op, a, d));
        done = 1;
      end
      n++;
    end
    if (!done) timeout_fail("send_store_timeout");
    @(posedge clk); #1;
    st_valid = 0;
  endtask

  task automatic complete_one();
    @(posedge clk); #1 data_sram_addr_ok = 1;
    @(posedge clk); #1 data_sram_addr_ok = 0; data_sram_data_ok = 1;
    @(posedge clk); #1 data_sram_data_ok = 0;
  endtask

  task automatic drain();
    int n = 0;
    @(posedge clk); #1 auto_resp = 1;
    while (pend.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) timeout_fail("drain_timeout");
    @(negedge clk);
    chk("drain_empty", sb_empty, 1);
    @(posedge clk); #1;
    auto_resp = 0; data_sram_addr_ok = 0; data_sram_data_ok = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic exp_far;
    st_valid = 0; st_op = 0; st_addr = 0; st_data = 0;
    data_sram_addr_ok = 0; data_sram_data_ok = 0;
    ld_valid = 0; ld_addr = 0;
    repeat (5) @(posedge clk);
    #1;

    // SB at 0x1003; also the one-cycle enqueue-to-request latency
    send_store(OP_SB, 32'h1003, 32'h0000_00AB);
    @(negedge clk);
    chk("latency_req", data_sram_req, 1);
    chk("sb_wstrb", data_sram_wstrb, 4'b1000);
    chk("sb_wdata", data_sram_wdata, 32'hABAB_ABAB);
    chk("sb_size", data_sram_size, 0);
    chk("sb_addr", data_sram_addr, 32'h1003);
    complete_one();

    // SWL / SWR partial-word stores
    send_store(OP_SWL, 32'h2001, 32'h1122_3344);
    @(negedge clk);
    chk("swl_wstrb", data_sram_wstrb, 4'b0011);
    chk("swl_wdata", data_sram_wdata, 32'h0000_1122);
    chk("swl_addr", data_sram_addr, 32'h2000);
    complete_one();
    send_store(OP_SWR, 32'h2002, 32'h1122_3344);
    @(negedge clk);
    chk("swr_wstrb", data_sram_wstrb, 4'b1100);
    chk("swr_wdata", data_sram_wdata, 32'h3344_0000);
    chk("swr_size", data_sram_size, 2);
    complete_one();

    // reserved opcode still issues, with no lanes
    send_store(3'd6, 32'h2104, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("rsvd_req", data_sram_req, 1);
    chk("rsvd_wstrb", data_sram_wstrb, 4'b0000);
    complete_one();

    // load probe against a pending store at 0x3004 (held in REQ)
    send_store(OP_SW, 32'h3004, 32'h0BAD_F00D);
    ld_valid = 1; ld_addr = 32'h3006;
    @(negedge clk);
    chk("ld_same_word", ld_stall, 1);
    @(posedge clk); #1 ld_addr = 32'h3008;
`ifdef STORE_BUF_ADDR_CHECK_EN
    exp_far = 1'b0;
`else
    exp_far = 1'b1;
`endif
    @(negedge clk);
    chk("ld_other_word", ld_stall, exp_far);
    @(posedge clk); #1 ld_valid = 0;
    @(negedge clk);
    chk("ld_idle", ld_stall, 0);
    complete_one();

    // fill to full with the SRAM stalled; pop and push collide on a full buffer
    for (int i = 0; i < DEPTH; i++) send_store(OP_SW, 32'h4000 + 32'(i * 4), $urandom());
    @(negedge clk);
    chk("full_flag", sb_full, 1);
    chk("full_ready", st_ready, 0);
    @(posedge clk); #1;
    st_valid = 1; st_op = OP_SB; st_addr = 32'h5001; st_data = 32'h0000_005A;
    repeat (2) begin
      @(negedge clk);
      chk("full_hold_ready", st_ready, 0);
    end
    @(posedge clk); #1 data_sram_addr_ok = 1;
    @(posedge clk); #1 data_sram_addr_ok = 0;
    @(negedge clk);
    chk("full_wait_state", dbg_state, ST_WAIT);
    @(posedge clk); #1 data_sram_data_ok = 1;
    @(negedge clk);
    chk("pop_cycle_ready", st_ready, 0);
    @(posedge clk); #1 data_sram_data_ok = 0;
    @(negedge clk);
    chk("after_pop_ready", st_ready, 1);
    chk("after_pop_full", sb_full, 0);
    if (st_ready) exp_q.push_back(model_fmt(OP_SB, 32'h5001, 32'h0000_005A));
    @(posedge clk); #1 st_valid = 0;
    @(negedge clk);
    chk("refill_full", sb_full, 1);
    drain();

    // reset while a write is outstanding; a late data_ok must be ignored
    send_store(OP_SW, 32'h7000, 32'h1111_1111);
    send_store(OP_SH, 32'h7006, 32'h2222_2222);
    data_sram_addr_ok = 1;
    @(posedge clk); #1 data_sram_addr_ok = 0;
    @(negedge clk);
    chk("pre_rst_wait", dbg_state, ST_WAIT);
    @(posedge clk); #1 resetn = 0;
    @(posedge clk); #1 resetn = 1;
    @(posedge clk); #1 data_sram_data_ok = 1;
    @(posedge clk); #1 data_sram_data_ok = 0;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_empty", sb_empty, 1);
      chk("post_rst_req", data_sram_req, 0);
      chk("post_rst_state", dbg_state, ST_IDLE);
    end
    @(posedge clk); #1;

    // randomized traffic with a randomly stalling SRAM and random load probes
    auto_resp = 1;
    ld_rand = 1;
    for (int i = 0; i < 250; i++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      send_store(3'($urandom_range(0, 7)), 32'h6000 + $urandom_range(0, 31), $urandom());
    end
    ld_rand = 0;
    @(posedge clk); #1 ld_valid = 0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
